// File: rtl/ooo_read_slave.sv
// ooo_read_slave
//   Out-of-order read responder. Accepts AR requests (one outstanding request
//   per ID) and answers each with a single R beat. In RANDOM mode the LFSR
//   chooses both the delay before each response and the ID search start
//   point. With RANDOM = 0 there is no delay and the lowest pending ID goes
//   first. Response data is ID + DATA_OFFSET.
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   s_arid_i     request ID
//   s_arvalid_i  request valid
//   s_arready_o  request ready; low while s_arid_i is already outstanding
//   s_rdata_o    response data (registered)
//   s_rid_o      response ID (registered)
//   s_rvalid_o   response valid (registered)
//   s_rready_i   response ready
//   pend_cnt_o   number of outstanding IDs (registered)
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no response in flight; leave as soon as any ID is pending
// ST_WAIT    | count down the response delay, then pick a pending ID
// ST_SEND    | R beat presented; hold until s_rready_i
module ooo_read_slave #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned ID_WIDTH    = 4,
    parameter int unsigned DATA_OFFSET = 10,
    parameter int unsigned DELAY_BITS  = 2,
    parameter int          RANDOM      = 1,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ID_WIDTH-1:0]   s_arid_i,
    input  logic                  s_arvalid_i,
    output logic                  s_arready_o,
    output logic [DATA_WIDTH-1:0] s_rdata_o,
    output logic [ID_WIDTH-1:0]   s_rid_o,
    output logic                  s_rvalid_o,
    input  logic                  s_rready_i,
    output logic [ID_WIDTH:0]     pend_cnt_o
);

    localparam int N_ID = 1 << ID_WIDTH;
    // An all-zero Fibonacci LFSR would lock up.
    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SEND
    } state_t;

    state_t                state_q, state_d;
    logic [DELAY_BITS-1:0] cnt_q, cnt_d;
    logic [N_ID-1:0]       pend_q, pend_nxt;
    logic [ID_WIDTH:0]     pend_cnt_q;
    logic [ID_WIDTH-1:0]   rid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [15:0]           lfsr_q;
    logic                  lfsr_fb;

    logic                  ar_hs;
    logic                  r_hs;
    logic                  load_sel;
    logic [ID_WIDTH-1:0]   search_start;
    logic [DELAY_BITS-1:0] delay_load;
    logic [ID_WIDTH-1:0]   probe;
    logic [ID_WIDTH-1:0]   sel_id;
    logic                  sel_found;

    assign s_arready_o = !pend_q[s_arid_i];
    assign ar_hs       = s_arvalid_i && s_arready_o;
    assign r_hs        = (state_q == ST_SEND) && s_rready_i;

    // Taps 16,14,13,11.
    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    assign search_start = (RANDOM != 0) ? lfsr_q[ID_WIDTH+7:8]    : '0;
    assign delay_load   = (RANDOM != 0) ? lfsr_q[DELAY_BITS-1:0] : '0;

    // First pending ID at or after search_start, wrapping around.
    always_comb begin
        sel_id    = '0;
        sel_found = 1'b0;
        probe     = '0;
        for (int i = 0; i < N_ID; i++) begin
            probe = search_start + ID_WIDTH'(i);
            if (!sel_found && pend_q[probe]) begin
                sel_id    = probe;
                sel_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        load_sel = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|pend_q) begin
                    state_d = ST_WAIT;
                    cnt_d   = delay_load;
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    // pend_q cannot be empty here: bits only clear in ST_SEND.
                    load_sel = 1'b1;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (s_rready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The R-side ID is pending, so it can never equal an accepted AR ID.
    always_comb begin
        pend_nxt = pend_q;
        if (r_hs) begin
            pend_nxt[rid_q] = 1'b0;
        end
        if (ar_hs) begin
            pend_nxt[s_arid_i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            pend_q     <= '0;
            pend_cnt_q <= '0;
            rid_q      <= '0;
            rdata_q    <= '0;
            lfsr_q     <= SEED;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_nxt;
            lfsr_q  <= {lfsr_q[14:0], lfsr_fb};
            if (load_sel) begin
                rid_q   <= sel_id;
                rdata_q <= DATA_WIDTH'(sel_id) + DATA_WIDTH'(DATA_OFFSET);
            end
            case ({ar_hs, r_hs})
                2'b10:   pend_cnt_q <= pend_cnt_q + 1'b1;
                2'b01:   pend_cnt_q <= pend_cnt_q - 1'b1;
                default: pend_cnt_q <= pend_cnt_q;
            endcase
        end
    end

    assign s_rvalid_o = (state_q == ST_SEND);
    assign s_rid_o    = rid_q;
    assign s_rdata_o  = rdata_q;
    assign pend_cnt_o = pend_cnt_q;

endmodule

// File: tb/tb_ooo_read_slave.sv
// Bench for ooo_read_slave: one deterministic instance (RANDOM = 0) checked
// cycle by cycle against a timing model, and one random instance (RANDOM = 1)
// checked against a pending-set scoreboard.
module tb_ooo_read_slave;

    localparam int IDW = 4;
    localparam int DW  = 8;
    localparam int NID = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [IDW-1:0] arid_d = '0;
    logic           arvalid_d = 1'b0;
    logic           arready_d;
    logic [DW-1:0]  rdata_d;
    logic [IDW-1:0] rid_d;
    logic           rvalid_d;
    logic           rready_d = 1'b0;
    logic [IDW:0]   cnt_d;

    logic [IDW-1:0] arid_r = '0;
    logic           arvalid_r = 1'b0;
    logic           arready_r;
    logic [DW-1:0]  rdata_r;
    logic [IDW-1:0] rid_r;
    logic           rvalid_r;
    logic           rready_r = 1'b0;
    logic [IDW:0]   cnt_r;

    ooo_read_slave #(
        .DATA_WIDTH(DW), .ID_WIDTH(IDW), .DATA_OFFSET(10), .DELAY_BITS(2),
        .RANDOM(0), .LFSR_SEED(16'hACE1)
    ) u_det (
        .clk(clk), .rst_n(rst_n),
        .s_arid_i(arid_d), .s_arvalid_i(arvalid_d), .s_arready_o(arready_d),
        .s_rdata_o(rdata_d), .s_rid_o(rid_d), .s_rvalid_o(rvalid_d),
        .s_rready_i(rready_d), .pend_cnt_o(cnt_d)
    );

    ooo_read_slave #(
        .DATA_WIDTH(DW), .ID_WIDTH(IDW), .DATA_OFFSET(10), .DELAY_BITS(2),
        .RANDOM(1), .LFSR_SEED(16'hACE1)
    ) u_rnd (
        .clk(clk), .rst_n(rst_n),
        .s_arid_i(arid_r), .s_arvalid_i(arvalid_r), .s_arready_o(arready_r),
        .s_rdata_o(rdata_r), .s_rid_o(rid_r), .s_rvalid_o(rvalid_r),
        .s_rready_i(rready_r), .pend_cnt_o(cnt_r)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- models ----------------
    int             e_cnt = 0;
    logic [NID-1:0] m_pend = '0;
    int             m_set [NID];
    logic           m_valid = 1'b0;
    logic [IDW-1:0] m_id = '0;
    int             m_cnt = 0;
    int             m_free = -100;
    logic           m_ar, m_r, m_ready, m_found;
    int             dr_id[$], dr_data[$], dr_edge[$];
    int             da_id[$], da_edge[$];

    logic [NID-1:0] r_pend = '0;
    int             r_set [NID];
    logic [NID-1:0] r_ret = '0;

    // Timing rules: a response goes valid at edge E when the slave has been
    // free since edge E-2 or earlier and some ID was already pending at E-2;
    // the lowest ID pending just before edge E is the one returned.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_pend  = '0;
                m_valid = 1'b0;
                m_id    = '0;
                m_cnt   = 0;
                m_free  = -100;
                r_pend  = '0;
            end else begin
                e_cnt++;
                m_ar = arvalid_d && !m_pend[arid_d];
                m_r  = m_valid && rready_d;
                if (m_r) begin
                    dr_id.push_back(int'(rid_d));
                    dr_data.push_back(int'(rdata_d));
                    dr_edge.push_back(e_cnt);
                    m_pend[m_id] = 1'b0;
                    m_valid      = 1'b0;
                    m_free       = e_cnt;
                    m_cnt--;
                end else if (!m_valid && m_free <= e_cnt - 2) begin
                    m_ready = 1'b0;
                    for (int i = 0; i < NID; i++)
                        if (m_pend[i] && m_set[i] <= e_cnt - 2) m_ready = 1'b1;
                    if (m_ready) begin
                        m_found = 1'b0;
                        for (int i = 0; i < NID; i++)
                            if (!m_found && m_pend[i]) begin
                                m_id    = IDW'(i);
                                m_found = 1'b1;
                            end
                        m_valid = 1'b1;
                    end
                end
                if (m_ar) begin
                    m_pend[arid_d] = 1'b1;
                    m_set[arid_d]  = e_cnt;
                    m_cnt++;
                    da_id.push_back(int'(arid_d));
                    da_edge.push_back(e_cnt);
                end
                if (arvalid_r && !r_pend[arid_r]) begin
                    r_pend[arid_r] = 1'b1;
                    r_set[arid_r]  = e_cnt;
                end
                if (rvalid_r && rready_r) begin
                    r_pend[rid_r] = 1'b0;
                    r_ret[rid_r]  = 1'b1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    bit             serial_mode = 1'b0;
    int             lat_min = 1000;
    int             lat_max = -1;
    int             lat;
    logic           prev_valid_r = 1'b0;
    logic           prev_rready_r = 1'b0;
    logic [IDW-1:0] prev_rid_r = '0;
    logic [DW-1:0]  prev_rdata_r = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid_r = 1'b0;
            end else begin
                check("det_arready", arready_d, !m_pend[arid_d]);
                check("det_rvalid", rvalid_d, m_valid);
                if (m_valid) begin
                    check("det_rid", rid_d, m_id);
                    check("det_rdata", rdata_d, (32'(m_id) + 10) & 32'hFF);
                end
                check("det_pend_cnt", cnt_d, m_cnt);

                check("rnd_arready", arready_r, !r_pend[arid_r]);
                check("rnd_pend_cnt", cnt_r, $countones(r_pend));
                if (rvalid_r) begin
                    check("rnd_rid_pending", r_pend[rid_r], 1);
                    check("rnd_rdata", rdata_r, (32'(rid_r) + 10) & 32'hFF);
                    check("rnd_unique", r_ret[rid_r], 0);
                    if (!prev_valid_r) begin
                        lat = e_cnt - r_set[rid_r];
                        if (serial_mode) begin
                            check("rnd_lat_ge2", lat >= 2, 1);
                            check("rnd_lat_le5", lat <= 5, 1);
                            if (lat < lat_min) lat_min = lat;
                            if (lat > lat_max) lat_max = lat;
                        end
                    end
                end
                if (prev_valid_r && !prev_rready_r) begin
                    check("rnd_hold_valid", rvalid_r, 1);
                    check("rnd_hold_rid", rid_r, prev_rid_r);
                    check("rnd_hold_rdata", rdata_r, prev_rdata_r);
                end
                prev_valid_r  = rvalid_r;
                prev_rready_r = rready_r;
                prev_rid_r    = rid_r;
                prev_rdata_r  = rdata_r;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ar_det(input int id);
        bit acc = 1'b0;
        arvalid_d = 1'b1;
        arid_d    = IDW'(id);
        for (int k = 0; k < 200 && !acc; k++) begin
            @(negedge clk);
            acc = arready_d;
            @(posedge clk);
            #1;
        end
        if (!acc) check("det_ar_timeout", 0, 1);
        arvalid_d = 1'b0;
    endtask

    task automatic ar_rnd(input int id);
        bit acc = 1'b0;
        arvalid_r = 1'b1;
        arid_r    = IDW'(id);
        for (int k = 0; k < 200 && !acc; k++) begin
            @(negedge clk);
            acc = arready_r;
            @(posedge clk);
            #1;
        end
        if (!acc) check("rnd_ar_timeout", 0, 1);
        arvalid_r = 1'b0;
    endtask

    task automatic wait_det_valid();
        bit seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            seen = rvalid_d;
        end
        if (!seen) check("det_rvalid_timeout", 0, 1);
    endtask

    task automatic clear_logs();
        dr_id.delete(); dr_data.delete(); dr_edge.delete();
        da_id.delete(); da_edge.delete();
    endtask

    int ids[NID];

    task automatic shuffle_ids();
        int j, t;
        for (int i = 0; i < NID; i++) ids[i] = i;
        for (int i = NID - 1; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            t = ids[i]; ids[i] = ids[j]; ids[j] = t;
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit done;
        #2 rst_n = 1'b0;
        #1;
        check("rst_det_arready", arready_d, 1);
        check("rst_det_rvalid", rvalid_d, 0);
        check("rst_det_rid", rid_d, 0);
        check("rst_det_rdata", rdata_d, 0);
        check("rst_det_cnt", cnt_d, 0);
        check("rst_rnd_arready", arready_r, 1);
        check("rst_rnd_rvalid", rvalid_r, 0);
        check("rst_rnd_rid", rid_r, 0);
        check("rst_rnd_rdata", rdata_r, 0);
        check("rst_rnd_cnt", cnt_r, 0);
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // Deterministic order: 5, 2, 9 back to back.
        clear_logs();
        rready_d = 1'b1;
        ar_det(5); ar_det(2); ar_det(9);
        tick(15);
        check("order_count", dr_id.size(), 3);
        if (dr_id.size() == 3 && da_id.size() == 3) begin
            check("order_id0", dr_id[0], 2);
            check("order_id1", dr_id[1], 5);
            check("order_id2", dr_id[2], 9);
            check("order_data0", dr_data[0], 12);
            check("order_data1", dr_data[1], 15);
            check("order_data2", dr_data[2], 19);
            check("order_first_ar", da_id[0], 5);
            check("order_first_lat", dr_edge[0] - da_edge[0], 3);
            check("order_gap01", dr_edge[1] - dr_edge[0], 3);
            check("order_gap12", dr_edge[2] - dr_edge[1], 3);
        end

        // Duplicate ID held until its response completes.
        clear_logs();
        rready_d = 1'b0;
        ar_det(3);
        arvalid_d = 1'b1;
        arid_d    = 3;
        tick(5);
        @(negedge clk);
        check("dup_blocked", arready_d, 0);
        @(posedge clk); #1;
        rready_d = 1'b1;
        ar_det(3);
        tick(10);
        check("dup_ar_count", da_id.size(), 2);
        if (da_id.size() == 2 && dr_id.size() >= 1) begin
            check("dup_first_rid", dr_id[0], 3);
            check("dup_accept_edge", da_edge[1] - dr_edge[0], 1);
        end

        // Full with back-pressure.
        clear_logs();
        rready_d = 1'b0;
        for (int i = 0; i < NID; i++) ar_det(i);
        @(negedge clk);
        check("full_cnt", cnt_d, 16);
        for (int i = 0; i < NID; i++) begin
            arid_d = IDW'(i);
            @(negedge clk);
            check("full_arready", arready_d, 0);
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("full_hold_valid", rvalid_d, 1);
            check("full_hold_rid", rid_d, 0);
        end
        @(posedge clk); #1;
        rready_d = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            done = (cnt_d == 0);
        end
        check("full_drain_done", done, 1);
        check("full_resp_count", dr_id.size(), 16);
        if (dr_id.size() == 16)
            for (int i = 0; i < NID; i++) check("full_resp_order", dr_id[i], i);
        tick(3);

        // Simultaneous AR (ID 7) and R (ID 1) handshakes.
        clear_logs();
        rready_d = 1'b0;
        ar_det(1);
        wait_det_valid();
        check("sim_cnt_before", cnt_d, 1);
        @(posedge clk); #1;
        arvalid_d = 1'b1;
        arid_d    = 7;
        rready_d  = 1'b1;
        @(posedge clk); #1;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        @(negedge clk);
        check("sim_cnt_after", cnt_d, 1);
        check("sim_pend7", arready_d, 0);
        arid_d = 1;
        #1;
        check("sim_pend1_clear", arready_d, 1);
        check("sim_r_id", (dr_id.size() == 1) ? dr_id[0] : -1, 1);
        @(posedge clk); #1;
        rready_d = 1'b1;
        tick(10);

        // Reset in the middle of a held response.
        rready_d = 1'b0;
        ar_det(4);
        arid_d = 4;
        wait_det_valid();
        check("rstmid_pend4", arready_d, 0);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_rvalid", rvalid_d, 0);
        check("rstmid_cnt", cnt_d, 0);
        check("rstmid_arready", arready_d, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(3);

        // Random instance: one serial round, then two burst rounds.
        shuffle_ids();
        r_ret       = '0;
        serial_mode = 1'b1;
        rready_r    = 1'b1;
        for (int i = 0; i < NID; i++) begin
            ar_rnd(ids[i]);
            done = 1'b0;
            for (int k = 0; k < 50 && !done; k++) begin
                @(negedge clk);
                done = (cnt_r == 0);
            end
            check("rnd_serial_done", done, 1);
            @(posedge clk); #1;
        end
        serial_mode = 1'b0;
        check("rnd_round0_all", r_ret, 16'hFFFF);
        check("rnd_lat_spread", lat_max > lat_min, 1);

        for (int round = 1; round < 3; round++) begin
            shuffle_ids();
            r_ret = '0;
            for (int i = 0; i < NID; i++) begin
                rready_r = 1'($urandom_range(1, 0));
                ar_rnd(ids[i]);
            end
            done = 1'b0;
            for (int k = 0; k < 1000 && !done; k++) begin
                @(negedge clk);
                done = (cnt_r == 0);
                if (!done) begin
                    @(posedge clk); #1;
                    rready_r = 1'($urandom_range(1, 0));
                end
            end
            check("rnd_burst_done", done, 1);
            @(posedge clk); #1;
            check("rnd_burst_all", r_ret, 16'hFFFF);
        end

        tick(3);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d, errors %0d", n_checks, n_errors);
        $fatal(1);
    end

endmodule
